// File: rtl/piso_tx_pkg.sv
// Shared USB hub datapath constants.
// The byte width is shared by the serial receiver and this transmitter so that
// both ends of the hub datapath always agree on how many bits make a byte.
package piso_tx_pkg;

    localparam int USB_BYTE_WIDTH = 8;

endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out byte transmitter for the USB hub datapath.
// Bytes arrive on a valid/ready handshake and leave LSB-first, one bit per clock.
// A one-entry holding register lets the next byte queue up while the current
// byte shifts out, so consecutive bytes leave with no idle cycle between them.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int DATA_WIDTH = USB_BYTE_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    input  logic                  p_data_in_val,
    output logic                  p_data_in_rdy,
    input  logic                  piso_cancel,
    output logic                  s_data_out,
    output logic                  s_data_out_val,
    output logic                  s_byte_last
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    // State encoding is private to this block.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic [CNT_W-1:0]      r_cnt;

    logic w_rdy;
    logic w_accept;
    logic w_last_bit;
    logic w_shifting;

    // Ready depends only on registers and the clearing inputs, never on valid,
    // so the upstream stage cannot form a combinational loop through us.
    assign w_rdy      = !r_hold_full && !piso_cancel && !rst;
    assign w_accept   = p_data_in_val && w_rdy;
    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last_bit = w_shifting && (r_cnt == LAST_BIT);

    assign p_data_in_rdy  = w_rdy;
    assign s_data_out     = r_shift[0];
    assign s_data_out_val = w_shifting;
    assign s_byte_last    = w_last_bit;

    // Main datapath and FSM: load, shift, refill from hold or bypass, or drain to idle.
    always_ff @(posedge clk) begin
        if (rst || piso_cancel) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
        end else if (r_state == ST_IDLE) begin
            // First byte of a burst goes straight into the shifter; hold stays empty.
            if (w_accept) begin
                r_shift <= p_data_in;
                r_cnt   <= '0;
                r_state <= ST_SHIFT;
            end
        end else if (w_last_bit) begin
            if (r_hold_full) begin
                // Queued byte continues the stream seamlessly.
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
                r_cnt       <= '0;
            end else if (w_accept) begin
                // Byte arriving exactly on the last bit bypasses the hold register.
                r_shift <= p_data_in;
                r_cnt   <= '0;
            end else begin
                // Nothing queued: the line goes quiet, marking end of packet downstream.
                r_state <= ST_IDLE;
                r_shift <= '0;
                r_cnt   <= '0;
            end
        end else begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_accept) begin
                r_hold      <= p_data_in;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx with hand-computed expected bit streams.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [7:0] dataIn;
    logic       dataInVal;
    logic       dataInRdy;
    logic       cancel;
    logic       sOut;
    logic       sVal;
    logic       sLast;

    int assertCount;
    int failCount;

    piso_tx #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .p_data_in      (dataIn),
        .p_data_in_val  (dataInVal),
        .p_data_in_rdy  (dataInRdy),
        .piso_cancel    (cancel),
        .s_data_out     (sOut),
        .s_data_out_val (sVal),
        .s_byte_last    (sLast)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all inputs at once, then let combinational ready settle.
    task automatic applyStimulus(input logic [7:0] d, input logic v,
                                 input logic c, input logic r);
        dataIn    = d;
        dataInVal = v;
        cancel    = c;
        rst       = r;
        #1;
    endtask

    // Advance to 1 ns after the next rising edge, away from the active edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check the three serial outputs for one cycle.
    task automatic checkCycle(input string tag, input logic expBit,
                              input logic expVal, input logic expLast);
        checkOutput({tag, ".out"},  sOut,  expBit);
        checkOutput({tag, ".val"},  sVal,  expVal);
        checkOutput({tag, ".last"}, sLast, expLast);
    endtask

    logic [15:0] word16;
    logic [23:0] word24;
    logic [7:0]  word8;

    initial begin
        assertCount = 0;
        failCount   = 0;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

        // Reset state.
        cycle();
        cycle();
        checkCycle("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.rdy_during_rst", dataInRdy, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.rdy_after_rst", dataInRdy, 1'b1);
        cycle();

        // Single byte 0xA5: bits 1,0,1,0,0,1,0,1 then underrun.
        $display("[TB] single byte 0xA5");
        word8 = 8'hA5;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        cycle();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkCycle($sformatf("a5.bit%0d", i), word8[i], 1'b1, i == 7);
            cycle();
        end
        checkCycle("a5.underrun", 1'b0, 1'b0, 1'b0);
        cycle();

        // Back-to-back 0x3C then 0xC3 via the holding register.
        $display("[TB] back-to-back 0x3C 0xC3");
        word16 = 16'hC33C;
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
            else        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
            if (i == 0) checkOutput("b2b.rdy_hold_empty", dataInRdy, 1'b1);
            if (i == 1) checkOutput("b2b.rdy_hold_full", dataInRdy, 1'b0);
            if (i == 8) checkOutput("b2b.rdy_after_drain", dataInRdy, 1'b1);
            checkCycle($sformatf("b2b.bit%0d", i), word16[i], 1'b1, (i % 8) == 7);
            cycle();
        end
        checkCycle("b2b.underrun", 1'b0, 1'b0, 1'b0);
        cycle();

        // Three bytes offered continuously: 0x11, 0x22, 0x33.
        $display("[TB] three continuous bytes");
        word24 = 24'h332211;
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 24; i++) begin
            if (i == 0)      applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
            else if (i <= 8) applyStimulus(8'h33, 1'b1, 1'b0, 1'b0);
            else             applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
            if (i == 1)  checkOutput("three.rdy_low_after_2nd", dataInRdy, 1'b0);
            if (i == 7)  checkOutput("three.rdy_low_at_last", dataInRdy, 1'b0);
            if (i == 8)  checkOutput("three.rdy_back", dataInRdy, 1'b1);
            if (i == 9)  checkOutput("three.rdy_low_after_3rd", dataInRdy, 1'b0);
            if (i == 16) checkOutput("three.rdy_final", dataInRdy, 1'b1);
            checkCycle($sformatf("three.bit%0d", i), word24[i], 1'b1, (i % 8) == 7);
            cycle();
        end
        checkCycle("three.underrun", 1'b0, 1'b0, 1'b0);
        cycle();

        // Bypass: 0x96 offered exactly on 0x5A's last-bit cycle with hold empty.
        $display("[TB] bypass path");
        word16 = 16'h965A;
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            if (i == 7) applyStimulus(8'h96, 1'b1, 1'b0, 1'b0);
            else        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
            if (i == 7) checkOutput("bypass.rdy_at_last", dataInRdy, 1'b1);
            checkCycle($sformatf("bypass.bit%0d", i), word16[i], 1'b1, (i % 8) == 7);
            cycle();
        end
        checkCycle("bypass.underrun", 1'b0, 1'b0, 1'b0);
        cycle();

        // Cancel during bit 3 of 0xFF with 0x0F queued; a byte offered during cancel is refused.
        $display("[TB] cancel mid-byte");
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
            else if (i == 3) applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
            else             applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
            if (i == 3) checkOutput("cancel.rdy_during", dataInRdy, 1'b0);
            checkCycle($sformatf("cancel.bit%0d", i), 1'b1, 1'b1, 1'b0);
            cycle();
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("cancel.rdy_after", dataInRdy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkCycle($sformatf("cancel.quiet%0d", i), 1'b0, 1'b0, 1'b0);
            cycle();
        end

        // Reset mid-byte with valid held high, then a fresh 0x81.
        $display("[TB] reset mid-byte");
        applyStimulus(8'hC7, 1'b1, 1'b0, 1'b0);
        cycle();
        applyStimulus(8'hE1, 1'b1, 1'b0, 1'b0);
        checkCycle("rst.bit0", 1'b1, 1'b1, 1'b0);
        cycle();
        checkCycle("rst.bit1", 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b1);
        checkOutput("rst.rdy_during", dataInRdy, 1'b0);
        cycle();
        checkCycle("rst.cleared", 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.rdy_after", dataInRdy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkCycle($sformatf("rst.quiet%0d", i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        word8 = 8'h81;
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        cycle();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkCycle($sformatf("post_rst.bit%0d", i), word8[i], 1'b1, i == 7);
            cycle();
        end
        checkCycle("post_rst.underrun", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
